// File: rtl/lps_pkg.sv
// Shared types and timing constants for the intersection phase scheduler.
// The scheduler and its round-robin selector both import this package.
package lps_pkg;

  localparam int TW         = 5;
  localparam int YELLOW_T   = 3;
  localparam int ALLRED_T   = 1;
  localparam int GREEN_DFLT = 10;
  localparam int NLANE      = 4;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    GREEN,
    YELLOW,
    ALLRED
  } state_e;

  // A zero-length green would stall the countdown, so it is promoted to one tick.
  function automatic logic [TW-1:0] sanitize_dur(input logic [TW-1:0] d);
    return (d == '0) ? TW'(1) : d;
  endfunction

  function automatic logic [NLANE-1:0] lane_onehot(input logic [1:0] lane);
    return NLANE'(1) << lane;
  endfunction

endpackage

// File: rtl/lps_rr_pick.sv
// Combinational 4-way round-robin selector: grants the first requesting lane
// after last_i, wrapping so that last_i itself has the lowest priority.
module lps_rr_pick
  import lps_pkg::*;
(
  input  logic [NLANE-1:0] req_i,
  input  logic [1:0]       last_i,
  output logic [1:0]       grant_idx_o,
  output logic             any_o
);

  logic [1:0] idx;

  // Walk from offset 4 (= last_i) down to offset 1 so the nearest requester wins.
  // NOTE: every variable written here gets a default first, otherwise paths that
  // skip an assignment would infer a latch.
  always_comb begin
    grant_idx_o = last_i;
    any_o       = 1'b0;
    idx         = last_i;
    for (int i = NLANE; i >= 1; i--) begin
      idx = last_i + 2'(i);
      if (req_i[idx]) begin
        grant_idx_o = idx;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/light_phase_sched.sv
// Phase scheduler for the four-way intersection: round-robin green over lanes
// with demand, then YELLOW and ALL-RED clearance, all timed by tick_i.
module light_phase_sched
  import lps_pkg::*;
(
  input  logic             clk,
  input  logic             arst_i,
  input  logic             tick_i,
  input  logic             run_i,
  input  logic [NLANE-1:0] req_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_sel_i,
  input  logic [TW-1:0]    cfg_green_i,
  output logic [NLANE-1:0] green_o,
  output logic [NLANE-1:0] yellow_o,
  output logic             all_red_o,
  output logic [1:0]       lane_o,
  output logic [TW-1:0]    remain_o
);

  state_e           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [1:0]       lane_q, lane_d;
  logic [TW-1:0]    dur_q [NLANE];
  logic [NLANE-1:0] green_q, green_d;
  logic [NLANE-1:0] yellow_q, yellow_d;
  logic             all_red_q, all_red_d;

  logic [1:0]       grant_idx;
  logic             grant_any;
  logic             step;
  logic             last_tick;
  logic [TW-1:0]    cfg_val;
  logic [TW-1:0]    green_load;

  lps_rr_pick u_rr_pick (
    .req_i       (req_i),
    .last_i      (lane_q),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  assign step      = tick_i & run_i;
  assign last_tick = step && (cnt_q == TW'(1));
  assign cfg_val   = sanitize_dur(cfg_green_i);

  // A write to the lane being granted this cycle is forwarded into the load.
  assign green_load = (cfg_we_i && (cfg_sel_i == grant_idx)) ? cfg_val : dur_q[grant_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    unique case (state_q)
      IDLE: begin
        if (run_i) state_d = PICK;
      end
      PICK: begin
        if (run_i) begin
          if (grant_any) begin
            state_d = GREEN;
            cnt_d   = green_load;
            lane_d  = grant_idx;
          end else begin
            state_d = ALLRED;
            cnt_d   = TW'(1);
          end
        end
      end
      GREEN: begin
        if (last_tick) begin
          state_d = YELLOW;
          cnt_d   = TW'(YELLOW_T);
        end else if (step) begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      YELLOW: begin
        if (last_tick) begin
          state_d = ALLRED;
          cnt_d   = TW'(ALLRED_T);
        end else if (step) begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      ALLRED: begin
        if (last_tick) begin
          state_d = PICK;
          cnt_d   = '0;
        end else if (step) begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamps are decoded from the next state so they register on the same edge.
  always_comb begin
    green_d   = (state_d == GREEN)  ? lane_onehot(lane_d) : '0;
    yellow_d  = (state_d == YELLOW) ? lane_onehot(lane_d) : '0;
    all_red_d = (state_d == IDLE) || (state_d == PICK) || (state_d == ALLRED);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lane_q    <= 2'd3;
      green_q   <= '0;
      yellow_q  <= '0;
      all_red_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      all_red_q <= all_red_d;
    end
  end

  // NOTE: unlike a RAM, this small duration file is reset so that every lane
  // restarts from the default green length after arst_i.
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      for (int l = 0; l < NLANE; l++) dur_q[l] <= TW'(GREEN_DFLT);
    end else if (cfg_we_i) begin
      dur_q[cfg_sel_i] <= cfg_val;
    end
  end

  assign green_o   = green_q;
  assign yellow_o  = yellow_q;
  assign all_red_o = all_red_q;
  assign lane_o    = lane_q;
  assign remain_o  = cnt_q;

endmodule

// File: tb/tb_light_phase_sched.sv
// Self-checking bench for light_phase_sched: a table of multi-tick steps plus
// hand-written sequences for config bypass, freeze and asynchronous reset.
module tb_light_phase_sched;

  logic       clk;
  logic       arst_i;
  logic       tick_i;
  logic       run_i;
  logic [3:0] req_i;
  logic       cfg_we_i;
  logic [1:0] cfg_sel_i;
  logic [4:0] cfg_green_i;
  logic [3:0] green_o;
  logic [3:0] yellow_o;
  logic       all_red_o;
  logic [1:0] lane_o;
  logic [4:0] remain_o;

  int tests = 0;
  int fails = 0;
  int inv_bad = 0;
  int bad_lit = 0;
  logic mon_en = 1'b0;

  light_phase_sched dut (
    .clk         (clk),
    .arst_i      (arst_i),
    .tick_i      (tick_i),
    .run_i       (run_i),
    .req_i       (req_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_sel_i   (cfg_sel_i),
    .cfg_green_i (cfg_green_i),
    .green_o     (green_o),
    .yellow_o    (yellow_o),
    .all_red_o   (all_red_o),
    .lane_o      (lane_o),
    .remain_o    (remain_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lamp invariant and "lanes 0/2 never lit" watch, sampled away from the edge.
  always @(negedge clk) begin
    if (!arst_i) begin
      if (($countones(green_o | yellow_o) > 1) || (all_red_o != ((green_o | yellow_o) == 4'b0)))
        inv_bad++;
      if (mon_en && (green_o[0] || green_o[2] || yellow_o[0] || yellow_o[2]))
        bad_lit++;
    end
  end

  typedef struct {
    string      name;
    logic       rst;
    logic       run;
    logic [3:0] req;
    int         ticks;
    logic [3:0] g;
    logic [3:0] y;
    logic       ar;
    logic [1:0] lane;
    logic [4:0] rem;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [3:0] y,
                           input logic ar, input logic [1:0] ln, input logic [4:0] rem);
    check({tag, ".green"},   32'(green_o),   32'(g));
    check({tag, ".yellow"},  32'(yellow_o),  32'(y));
    check({tag, ".all_red"}, 32'(all_red_o), 32'(ar));
    check({tag, ".lane"},    32'(lane_o),    32'(ln));
    check({tag, ".remain"},  32'(remain_o),  32'(rem));
  endtask

  task automatic do_reset();
    arst_i      = 1'b1;
    tick_i      = 1'b0;
    run_i       = 1'b0;
    req_i       = 4'b0;
    cfg_we_i    = 1'b0;
    cfg_sel_i   = 2'd0;
    cfg_green_i = 5'd0;
    repeat (2) @(negedge clk);
    arst_i = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // One tick strobe followed by idle cycles so PICK can resolve between ticks.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      tick_i = 1'b1;
      @(negedge clk);
      tick_i = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [4:0] val);
    cfg_we_i    = 1'b1;
    cfg_sel_i   = sel;
    cfg_green_i = val;
    @(negedge clk);
    cfg_we_i    = 1'b0;
  endtask

  initial begin
    arst_i = 1'b1;
    tick_i = 1'b0;
    run_i  = 1'b0;
    req_i  = 4'b0;
    cfg_we_i = 1'b0;
    cfg_sel_i = 2'd0;
    cfg_green_i = 5'd0;

    // Round-robin over lanes 1 and 3, then the no-demand ALLRED/PICK loop.
    vecs.push_back('{"rr_first",  1'b1, 1'b1, 4'b1010,  0, 4'b0010, 4'b0000, 1'b0, 2'd1, 5'd10});
    vecs.push_back('{"rr_yel1",   1'b0, 1'b1, 4'b1010, 10, 4'b0000, 4'b0010, 1'b0, 2'd1, 5'd3});
    vecs.push_back('{"rr_lane3",  1'b0, 1'b1, 4'b1010,  4, 4'b1000, 4'b0000, 1'b0, 2'd3, 5'd10});
    vecs.push_back('{"rr_back1",  1'b0, 1'b1, 4'b1010, 14, 4'b0010, 4'b0000, 1'b0, 2'd1, 5'd10});
    vecs.push_back('{"rr_allred", 1'b0, 1'b1, 4'b1010, 13, 4'b0000, 4'b0000, 1'b1, 2'd1, 5'd1});
    vecs.push_back('{"rr_lane3b", 1'b0, 1'b1, 4'b1010,  1, 4'b1000, 4'b0000, 1'b0, 2'd3, 5'd10});
    vecs.push_back('{"nd_start",  1'b1, 1'b1, 4'b0000,  0, 4'b0000, 4'b0000, 1'b1, 2'd3, 5'd1});
    vecs.push_back('{"nd_loop",   1'b0, 1'b1, 4'b0000,  3, 4'b0000, 4'b0000, 1'b1, 2'd3, 5'd1});
    vecs.push_back('{"nd_req_up", 1'b0, 1'b1, 4'b1000,  0, 4'b0000, 4'b0000, 1'b1, 2'd3, 5'd1});
    vecs.push_back('{"nd_lane3",  1'b0, 1'b1, 4'b1000,  1, 4'b1000, 4'b0000, 1'b0, 2'd3, 5'd10});

    // Reset defaults, lane 0 alone for 40 ticks.
    do_reset();
    check_out("reset", 4'b0000, 4'b0000, 1'b1, 2'd3, 5'd0);
    run_i = 1'b1;
    req_i = 4'b0001;
    settle();
    for (int k = 0; k < 10; k++) begin
      check_out($sformatf("t1_green%0d", k), 4'b0001, 4'b0000, 1'b0, 2'd0, 5'(10 - k));
      tick(1);
    end
    check_out("t1_yellow", 4'b0000, 4'b0001, 1'b0, 2'd0, 5'd3);
    tick(3);
    check_out("t1_allred", 4'b0000, 4'b0000, 1'b1, 2'd0, 5'd1);
    tick(1);
    check_out("t1_regreen", 4'b0001, 4'b0000, 1'b0, 2'd0, 5'd10);
    tick(14);
    check_out("t1_green3", 4'b0001, 4'b0000, 1'b0, 2'd0, 5'd10);
    tick(12);
    check_out("t1_end40", 4'b0000, 4'b0001, 1'b0, 2'd0, 5'd1);

    // Table-driven steps.
    mon_en = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      if (v.rst) do_reset();
      run_i = v.run;
      req_i = v.req;
      settle();
      tick(v.ticks);
      check_out(v.name, v.g, v.y, v.ar, v.lane, v.rem);
    end
    mon_en = 1'b0;
    check("rr_lanes02_dark", 32'(bad_lit), 32'd0);

    // Config: zero write in IDLE, then a write bypassed into PICK's load.
    do_reset();
    cfg_write(2'd2, 5'd0);
    check_out("cfg_idle", 4'b0000, 4'b0000, 1'b1, 2'd3, 5'd0);
    req_i = 4'b0100;
    run_i = 1'b1;
    @(negedge clk);
    cfg_write(2'd2, 5'd4);
    check_out("cfg_bypass", 4'b0100, 4'b0000, 1'b0, 2'd2, 5'd4);
    cfg_write(2'd2, 5'd0);
    check("cfg_cnt_kept", 32'(remain_o), 32'd4);
    tick(3);
    check_out("cfg_g4_last", 4'b0100, 4'b0000, 1'b0, 2'd2, 5'd1);
    tick(1);
    check_out("cfg_g4_yel", 4'b0000, 4'b0100, 1'b0, 2'd2, 5'd3);
    tick(4);
    check_out("cfg_g1", 4'b0100, 4'b0000, 1'b0, 2'd2, 5'd1);
    tick(1);
    check_out("cfg_g1_yel", 4'b0000, 4'b0100, 1'b0, 2'd2, 5'd3);

    // Freeze mid-green at remain 6.
    do_reset();
    run_i = 1'b1;
    req_i = 4'b0001;
    settle();
    tick(4);
    check("frz_rem6", 32'(remain_o), 32'd6);
    run_i = 1'b0;
    tick(20);
    check_out("frz_held", 4'b0001, 4'b0000, 1'b0, 2'd0, 5'd6);
    run_i = 1'b1;
    tick(5);
    check_out("frz_last", 4'b0001, 4'b0000, 1'b0, 2'd0, 5'd1);
    tick(1);
    check_out("frz_yel", 4'b0000, 4'b0001, 1'b0, 2'd0, 5'd3);

    // Asynchronous reset mid-yellow restores outputs and durations.
    do_reset();
    cfg_write(2'd0, 5'd5);
    run_i = 1'b1;
    req_i = 4'b0001;
    settle();
    check_out("ar_dur5", 4'b0001, 4'b0000, 1'b0, 2'd0, 5'd5);
    tick(6);
    check_out("ar_mid_yel", 4'b0000, 4'b0001, 1'b0, 2'd0, 5'd2);
    #2 arst_i = 1'b1;
    #1;
    check_out("ar_async", 4'b0000, 4'b0000, 1'b1, 2'd3, 5'd0);
    repeat (2) @(negedge clk);
    arst_i = 1'b0;
    settle();
    check_out("ar_dur10", 4'b0001, 4'b0000, 1'b0, 2'd0, 5'd10);

    check("lamp_invariant", 32'(inv_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
